// File: rtl/solver_dispatcher.sv
// Raster-order pixel job scheduler feeding a bank of escape-time solvers with round-robin grants.
// Optional build macro DISPATCHER_PERF_EN adds a saturating frame cycle counter on perf_cycles.
module solver_dispatcher #(
    parameter int NUM_SOLVERS = 10,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int CW          = 27
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CW-1:0]          min_x,
    input  logic [CW-1:0]          min_y,
    input  logic [CW-1:0]          dx,
    input  logic [CW-1:0]          dy,
    input  logic [NUM_SOLVERS-1:0] req,
    input  logic [NUM_SOLVERS-1:0] retire,
    output logic [NUM_SOLVERS-1:0] grant,
    output logic [9:0]             job_x,
    output logic [8:0]             job_y,
    output logic [18:0]            job_addr,
    output logic [CW-1:0]          job_cr,
    output logic [CW-1:0]          job_ci,
    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            perf_cycles
);
    localparam int PW = $clog2(NUM_SOLVERS);
    localparam logic [9:0] LAST_X = 10'(WIDTH - 1);
    localparam logic [8:0] LAST_Y = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic                   [NUM_SOLVERS-1:0] r_inflight, r_grant;
    logic                   [PW-1:0]          r_ptr;
    logic                   [9:0]             r_x, r_job_x;
    logic                   [8:0]             r_y, r_job_y;
    logic                   [18:0]            r_addr, r_job_addr;
    logic signed            [CW-1:0]          r_cr, r_ci, r_job_cr, r_job_ci;
    logic signed            [CW-1:0]          r_min_x, r_dx, r_dy;

    logic [NUM_SOLVERS-1:0] w_eligible, w_grant_vec;
    logic [PW-1:0]          w_sel, w_idx, w_ptr_nxt;
    logic                   w_found, w_do_grant, w_last, w_accept, w_busy;
    int                     w_sum;

    // Round-robin search: first eligible solver at or after the pointer, wrapping.
    always_comb begin
        w_eligible = req & ~r_inflight & ~r_grant;
        w_found    = 1'b0;
        w_sel      = '0;
        w_sum      = 0;
        w_idx      = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NUM_SOLVERS) w_sum = w_sum - NUM_SOLVERS;
            w_idx = PW'(w_sum);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        w_grant_vec = NUM_SOLVERS'(1) << w_sel;
        w_ptr_nxt   = (w_sel == PW'(NUM_SOLVERS - 1)) ? '0 : w_sel + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_do_grant  = 1'b0;
        w_last      = (r_x == LAST_X) && (r_y == LAST_Y);
        case (r_state)
            IDLE: begin
                w_accept = start;
                if (start) w_state_nxt = DISPATCH;
            end
            DISPATCH: begin
                w_do_grant = w_found;
                if (w_found && w_last) w_state_nxt = DRAIN;
            end
            DRAIN:   if (r_inflight == '0) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_cr       <= '0;
            r_ci       <= '0;
            r_min_x    <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_job_x    <= '0;
            r_job_y    <= '0;
            r_job_addr <= '0;
            r_job_cr   <= '0;
            r_job_ci   <= '0;
        end else begin
            // Retire clears before the new grant sets, so both apply in one cycle.
            r_inflight <= (r_inflight & ~retire) | (w_do_grant ? w_grant_vec : '0);
            r_grant    <= w_do_grant ? w_grant_vec : '0;
            if (w_accept) begin
                r_min_x <= min_x;
                r_dx    <= dx;
                r_dy    <= dy;
                r_x     <= '0;
                r_y     <= '0;
                r_addr  <= '0;
                r_cr    <= min_x;
                r_ci    <= min_y;
            end
            if (w_do_grant) begin
                r_ptr      <= w_ptr_nxt;
                r_job_x    <= r_x;
                r_job_y    <= r_y;
                r_job_addr <= r_addr;
                r_job_cr   <= r_cr;
                r_job_ci   <= r_ci;
                r_addr     <= r_addr + 19'd1;
                if (r_x == LAST_X) begin
                    r_x  <= '0;
                    r_cr <= r_min_x;
                    r_y  <= r_y + 9'd1;
                    r_ci <= r_ci + r_dy;
                end else begin
                    r_x  <= r_x + 10'd1;
                    r_cr <= r_cr + r_dx;
                end
            end
        end
    end

    assign w_busy     = (r_state != IDLE);
    assign busy       = w_busy;
    assign frame_done = (r_state == DONE);
    assign grant      = r_grant;
    assign job_x      = r_job_x;
    assign job_y      = r_job_y;
    assign job_addr   = r_job_addr;
    assign job_cr     = r_job_cr;
    assign job_ci     = r_job_ci;

`ifdef DISPATCHER_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             r_perf <= '0;
        else if (w_accept)                     r_perf <= '0;
        else if (w_busy && (r_perf != '1))     r_perf <= r_perf + 32'd1;
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_solver_dispatcher.sv
// Directed scoreboard bench for solver_dispatcher on a 4x2 frame with three solvers.
module tb_solver_dispatcher;
    localparam int N  = 3;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 27;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] min_x = '0, min_y = '0, dx = '0, dy = '0;
    logic [N-1:0]  req = '0, retire = '0, grant;
    logic [9:0]    job_x;
    logic [8:0]    job_y;
    logic [18:0]   job_addr;
    logic [CW-1:0] job_cr, job_ci;
    logic          busy, frame_done;
    logic [31:0]   perf_cycles;

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;
    bit hold_en  = 1'b0;
    bit held     = 1'b0;
    logic [N-1:0] granted_or = '0;

    typedef struct {
        int            x;
        int            y;
        int            addr;
        logic [CW-1:0] cr;
        logic [CW-1:0] ci;
        int            sol;
    } job_t;
    job_t exp_q[$];

    solver_dispatcher #(.NUM_SOLVERS(N), .WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy),
        .req(req), .retire(retire), .grant(grant),
        .job_x(job_x), .job_y(job_y), .job_addr(job_addr),
        .job_cr(job_cr), .job_ci(job_ci),
        .busy(busy), .frame_done(frame_done), .perf_cycles(perf_cycles)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_grant"}, 64'(grant), 64'd0);
        chk({pfx, "_job_x"}, 64'(job_x), 64'd0);
        chk({pfx, "_job_y"}, 64'(job_y), 64'd0);
        chk({pfx, "_job_addr"}, 64'(job_addr), 64'd0);
        chk({pfx, "_job_cr"}, 64'(job_cr), 64'd0);
        chk({pfx, "_job_ci"}, 64'(job_ci), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({pfx, "_perf"}, 64'(perf_cycles), 64'd0);
    endtask

    // mode 1: rotate from solver 0; mode 2: alternate 0,2; otherwise solver not checked
    task automatic push_frame(input int mx, input int my, input int ddx, input int ddy, input int mode);
        job_t e;
        exp_q.delete();
        for (int i = 0; i < W * H; i++) begin
            e.x    = i % W;
            e.y    = i / W;
            e.addr = i;
            e.cr   = CW'(mx + e.x * ddx);
            e.ci   = CW'(my + e.y * ddy);
            case (mode)
                1:       e.sol = i % N;
                2:       e.sol = (i % 2 == 0) ? 0 : 2;
                default: e.sol = -1;
            endcase
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        job_t e;
        int   idx;
        @(posedge clock);
        #1;
        retire = '0;
        if (busy) busy_cnt++;
        if (grant != '0) begin
            idx = -1;
            for (int i = 0; i < N; i++) if (grant[i]) idx = i;
            granted_or = granted_or | grant;
            chk("grant_onehot", 64'($countones(grant)), 64'd1);
            chk("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("job_x", 64'(job_x), 64'(e.x));
                chk("job_y", 64'(job_y), 64'(e.y));
                chk("job_addr", 64'(job_addr), 64'(e.addr));
                chk("job_cr", 64'(job_cr), 64'(e.cr));
                chk("job_ci", 64'(job_ci), 64'(e.ci));
                if (e.sol >= 0) chk("grant_solver", 64'(idx), 64'(e.sol));
                if (hold_en && idx == 1 && e.addr == W * H - 1) held = 1'b1;
                else retire = grant;
            end
        end
    endtask

    task automatic start_frame(input int mx, input int my, input int ddx, input int ddy);
        min_x    = CW'(mx);
        min_y    = CW'(my);
        dx       = CW'(ddx);
        dy       = CW'(ddy);
        start    = 1'b1;
        busy_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("frame_done_seen", 64'(frame_done), 64'd1);
    endtask

    task automatic finish_frame();
        chk("all_jobs_granted", 64'(exp_q.size()), 64'd0);
        tick();
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(frame_done), 64'd0);
`ifdef DISPATCHER_PERF_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(busy_cnt));
`else
        chk("perf_cycles", 64'(perf_cycles), 64'd0);
`endif
    endtask

    initial begin
        int n;
        #2 reset = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Fairness: only solvers 0 and 2 request
        req        = 3'b101;
        granted_or = '0;
        push_frame(0, 0, 1, 1, 2);
        start_frame(0, 0, 1, 1);
        wait_done(200);
        finish_frame();
        chk("solver1_never_granted", 64'(granted_or[1]), 64'd0);

        // Full sweep with coordinate walk, instant retire
        req = 3'b111;
        push_frame(-2097152, -1048576, 4915, 4369, 1);
        start_frame(-2097152, -1048576, 4915, 4369);
        wait_done(200);
        finish_frame();

        // Start pulsed mid-frame with a different min_x is ignored
        push_frame(1048576, 0, 100, 200, 0);
        start_frame(1048576, 0, 100, 200);
        tick();
        min_x = CW'(-5242880);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_restart_attempt", 64'(busy), 64'd1);
        wait_done(200);
        finish_frame();

        // Reset after five grants
        push_frame(0, 0, 10, 10, 0);
        start_frame(0, 0, 10, 10);
        n = 0;
        while ((W * H - exp_q.size()) < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("five_grants", 64'(W * H - exp_q.size()), 64'd5);
        #2 reset = 1'b1;
        retire = '0;
        #1 check_zero("midreset");
        @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();

        // Drain: solver 1 holds the last job for 20 cycles
        hold_en = 1'b1;
        held    = 1'b0;
        push_frame(-2097152, -1048576, 4915, 4369, 1);
        start_frame(-2097152, -1048576, 4915, 4369);
        n = 0;
        while (!held && n < 100) begin
            tick();
            n++;
        end
        chk("last_job_held", 64'(held), 64'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("drain_no_done", 64'(frame_done), 64'd0);
            chk("drain_busy", 64'(busy), 64'd1);
        end
        retire = 3'b010;
        tick();
        chk("done_not_in_retire_cycle", 64'(frame_done), 64'd0);
        chk("busy_at_retire", 64'(busy), 64'd1);
        tick();
        chk("done_after_retire", 64'(frame_done), 64'd1);
        chk("busy_during_done", 64'(busy), 64'd1);
        finish_frame();
        hold_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/solver_dispatcher.md
# solver_dispatcher

Work scheduler that sits between the frame parameters and a bank of `NUM_SOLVERS` escape-time solvers. It walks the frame in raster order and computes each pixel's complex coordinate incrementally. It hands one pixel job per cycle to an idle solver using round-robin arbitration. It tracks outstanding jobs so it can signal completion once every pixel of the frame has been solved.

## Interface
- `NUM_SOLVERS`, 10: number of requesting solvers (2..32).
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: lines per frame.
- `CW`, 27: coordinate width, signed fixed point, 20 fractional bits.

- `clock`  in  1: single clock domain. One clock; reset is asynchronous and active-high.
- `reset`  in  1: asynchronous, active-high, returns the block to IDLE.
- `start`  in  1: single-cycle frame request; honoured only in IDLE.
- `min_x`, `min_y`  in  CW: signed coordinate of pixel (0,0); latched on an accepted `start`.
- `dx`, `dy`  in  CW: signed per-pixel and per-line step; latched on an accepted `start`.
- `req`  in  NUM_SOLVERS: bit i high means solver i is idle and wants a job.
- `retire`  in  NUM_SOLVERS: bit i pulses for one cycle when solver i finishes its job.
- `grant`  out  NUM_SOLVERS: one-hot for one cycle; delivers the job to solver i.
- `job_x`  out  10: pixel column.
- `job_y`  out  9: pixel row.
- `job_addr`  out  19: `job_y*WIDTH + job_x`.
- `job_cr`, `job_ci`  out  CW: complex coordinate of the pixel.
- `busy`  out  1: high in every state except IDLE.
- `frame_done`  out  1: one-cycle pulse when the frame completes.
- `perf_cycles`  out  32: frame cycle count (see Configuration).

## Operation
- **Reset values:** every output is 0. State is IDLE, the round-robin pointer is 0, and all per-solver busy bits are cleared.
- **States:**
  - IDLE: on `start`, latch `min_x`, `min_y`, `dx`, `dy`; set x=0, y=0, cr=min_x, ci=min_y; go to DISPATCH.
  - DISPATCH: each cycle, form `eligible = req & ~inflight & ~grant_q`. If it is non-zero, grant the first eligible bit at or after the pointer (wrapping), register the job fields, set `inflight[i]`, and move the pointer to i+1 mod NUM_SOLVERS. When the granted pixel is (WIDTH-1, HEIGHT-1), go to DRAIN.
  - DRAIN: no grants are issued. When `inflight` is 0, go to DONE.
  - DONE: pulse `frame_done`, then go to IDLE.
- **Coordinate advance after each grant:**
  - x < WIDTH-1: x += 1, cr += dx.
  - Otherwise: x = 0, cr = min_x, y += 1, ci += dy.
  - Adds wrap modulo 2^CW and are not saturated.
  - `job_addr` comes from its own incrementing counter, not a multiplier.
- **Retire:** `retire[i]` clears `inflight[i]`. A retire on a solver with no job in flight is ignored. Retire is accepted in every state.
- **Start while busy:** ignored. The latched parameters do not change during a frame.
- **Simultaneous events:** grant to solver i and retire from solver j≠i in the same cycle are both applied. Solver i cannot be granted while `inflight[i]` is set.
- **Masking rule:** the `grant_q` mask prevents a second grant to a solver that has not yet dropped `req`.
- **Reset mid-frame:** all progress is discarded, and in-flight jobs are forgotten. No `frame_done` is produced.

## Timing
- `req` sampled in cycle t produces a registered `grant` and job fields in cycle t+1.
- Job fields are valid only while `grant` is non-zero and hold their value otherwise.
- Peak throughput is one job per cycle. A frame needs at least WIDTH×HEIGHT DISPATCH cycles.
- The solver must drop `req` no later than the cycle after it sees `grant`.
- The transition to DRAIN takes effect in the cycle after the last grant.
- `frame_done` is asserted exactly one cycle after `inflight` reaches 0 in DRAIN.
- `busy` falls in the cycle after the `frame_done` pulse.

## Configuration
- `DISPATCHER_PERF_EN`
  - Defined: `perf_cycles` clears on an accepted `start`, increments every cycle while `busy` is high, and holds its value after `frame_done` until the next `start`. It saturates at 2^32-1.
  - Undefined: `perf_cycles` is tied to 0 and no counter logic is built.

## Test plan
- **Full sweep:** WIDTH=4, HEIGHT=2, N=3, `req` held all-ones with instant retire. Required: 8 grants with `job_addr` 0..7, grants rotating 001,010,100,…, followed by `frame_done`.
- **Coordinate walk:** `min_x`=-2<<20, `dx`=4915, `min_y`=-1<<20, `dy`=4369. Required: pixel (3,0) has `job_cr`=-2097152+14745; pixel (0,1) has `job_cr`=-2097152 and `job_ci`=-1048576+4369.
- **Drain:** solver 1 holds its last job for 20 cycles after the final grant. Required: `frame_done` stays low until the cycle after `retire[1]`, and `busy` stays high throughout.
- **Fairness:** only solvers 0 and 2 requesting continuously. Required: grants alternate 0,2,0,2; solver 1 is never granted.
- **Start while busy:** `start` pulsed in DISPATCH with different `min_x`. Required: ignored, and the frame completes with the original coordinates.
- **Reset mid-frame:** `reset` asserted after 5 grants. Required: all outputs are 0 asynchronously. After release, `start` restarts from `job_addr`=0; with `DISPATCHER_PERF_EN`, `perf_cycles` equals the frame's busy-cycle count.
